// File: rtl/five_arb_ctrl_if.sv
// Bus bundle for five_arb_ctrl: two requesters, the shared A/B datapath,
// the response channel and status outputs.
interface five_arb_ctrl_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [2:0] req0_a;
    logic [2:0] req1_a;
    logic [3:0] req0_b;
    logic [3:0] req1_b;
    logic       req0_ready;
    logic       req1_ready;
    logic [2:0] dp_a;
    logic [3:0] dp_b;
    logic [4:0] dp_c;
    logic       dp_c1;
    logic       dp_c2;
    logic       rsp_valid;
    logic       rsp_id;
    logic [4:0] rsp_c;
    logic       rsp_c1;
    logic       rsp_c2;
    logic       rsp_ready;
    logic       busy;
    logic [7:0] op_cnt;

    // Controller side.
    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
        input  dp_c, dp_c1, dp_c2, rsp_ready,
        output req0_ready, req1_ready, dp_a, dp_b,
        output rsp_valid, rsp_id, rsp_c, rsp_c1, rsp_c2, busy, op_cnt
    );

    // Requester / datapath / consumer side.
    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
        output dp_c, dp_c1, dp_c2, rsp_ready,
        input  req0_ready, req1_ready, dp_a, dp_b,
        input  rsp_valid, rsp_id, rsp_c, rsp_c1, rsp_c2, busy, op_cnt
    );
endinterface

// File: rtl/five_arb_ctrl.sv
// Two-requester round-robin controller for a shared combinational A/B
// datapath: accept one operation, hold operands for HOLD_CYCLES settle
// cycles, capture the result and present it until the consumer takes it.
module five_arb_ctrl #(
    parameter int unsigned HOLD_CYCLES = 1  // legal 1..15
) (
    input logic            clk,
    input logic            rst_n,
    five_arb_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [4:0] rsp_c_q, rsp_c_d;
    logic       rsp_c1_q, rsp_c1_d;
    logic       rsp_c2_q, rsp_c2_d;
    logic [7:0] op_cnt_q, op_cnt_d;

    logic any_valid;
    logic grant;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst_n so it drops the instant reset asserts, even with valid held high.
    assign bus.req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant;

    // Next-state and datapath-capture logic.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_c_d      = rsp_c_q;
        rsp_c1_d     = rsp_c1_q;
        rsp_c2_d     = rsp_c2_q;
        op_cnt_d     = op_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d          = grant ? bus.req1_a : bus.req0_a;
                    b_d          = grant ? bus.req1_b : bus.req0_b;
                    id_d         = grant;
                    last_grant_d = grant;
                    cnt_d        = SETTLE_INIT;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == 4'd0) begin
                    rsp_c_d     = bus.dp_c;
                    rsp_c1_d    = bus.dp_c1;
                    rsp_c2_d    = bus.dp_c2;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = op_cnt_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_c_q      <= '0;
            rsp_c1_q     <= 1'b0;
            rsp_c2_q     <= 1'b0;
            op_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_c_q      <= rsp_c_d;
            rsp_c1_q     <= rsp_c1_d;
            rsp_c2_q     <= rsp_c2_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign bus.dp_a      = a_q;
    assign bus.dp_b      = b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_c1    = rsp_c1_q;
    assign bus.rsp_c2    = rsp_c2_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_five_arb_ctrl.sv
// Directed bench for five_arb_ctrl: one instance with HOLD_CYCLES=1 and one
// with HOLD_CYCLES=4, each fed by a combinational adder/compare datapath.
module tb_five_arb_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    five_arb_ctrl_if b1 ();
    five_arb_ctrl_if b4 ();

    five_arb_ctrl #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    five_arb_ctrl #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    // Datapath model: c = a + b, c1 = (a == b), c2 = (a > b).
    assign b1.dp_c  = {2'b00, b1.dp_a} + {1'b0, b1.dp_b};
    assign b1.dp_c1 = ({1'b0, b1.dp_a} == b1.dp_b);
    assign b1.dp_c2 = ({1'b0, b1.dp_a} >  b1.dp_b);
    assign b4.dp_c  = {2'b00, b4.dp_a} + {1'b0, b4.dp_b};
    assign b4.dp_c1 = ({1'b0, b4.dp_a} == b4.dp_b);
    assign b4.dp_c2 = ({1'b0, b4.dp_a} >  b4.dp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        b1.req0_valid = 0; b1.req1_valid = 0; b1.req0_a = 0; b1.req1_a = 0;
        b1.req0_b = 0; b1.req1_b = 0; b1.rsp_ready = 0;
        b4.req0_valid = 0; b4.req1_valid = 0; b4.req0_a = 0; b4.req1_a = 0;
        b4.req0_b = 0; b4.req1_b = 0; b4.rsp_ready = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b1.rsp_valid, b1.rsp_id, b1.rsp_c, b1.rsp_c1, b1.rsp_c2,
             b1.req0_ready, b1.req1_ready, b1.busy} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs_h1: got %h expected 000",
                     {b1.rsp_valid, b1.rsp_id, b1.rsp_c, b1.rsp_c1, b1.rsp_c2,
                      b1.req0_ready, b1.req1_ready, b1.busy});
        end
        checks++;
        if ({b1.dp_a, b1.dp_b, b1.op_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dp_cnt_h1: got dp_a=%0d dp_b=%0d op_cnt=%0d expected 0/0/0",
                     b1.dp_a, b1.dp_b, b1.op_cnt);
        end
        // Ready must stay low during reset even with a requester valid.
        b1.req0_valid = 1'b1;
        #1;
        checks++;
        if (b1.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_gated: got %b expected 0", b1.req0_ready);
        end
        b1.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (b4.busy !== 1'b0 || b4.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_h4: got busy=%b rsp_valid=%b expected 0/0",
                     b4.busy, b4.rsp_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        b1.req0_valid = 1; b1.req0_a = 3'b010; b1.req0_b = 4'b1000; b1.rsp_ready = 0;
        #1;
        checks++;
        if (b1.req0_ready !== 1'b1 || b1.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got r0=%b r1=%b expected 1/0", b1.req0_ready, b1.req1_ready);
        end
        @(negedge clk);  // accept edge passed, now in ISSUE
        b1.req0_valid = 0;
        checks++;
        if (b1.busy !== 1'b1 || b1.rsp_valid !== 1'b0 || b1.dp_a !== 3'd2 || b1.dp_b !== 4'd8) begin
            errors++;
            $display("FAIL single_issue: got busy=%b rsp_valid=%b dp_a=%0d dp_b=%0d expected 1/0/2/8",
                     b1.busy, b1.rsp_valid, b1.dp_a, b1.dp_b);
        end
        @(negedge clk);  // one edge after accept
        checks++;
        if (b1.rsp_valid !== 1'b1 || b1.rsp_id !== 1'b0 || b1.rsp_c !== 5'd10 ||
            b1.rsp_c1 !== 1'b0 || b1.rsp_c2 !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%b c=%0d c1=%b c2=%b expected 1/0/10/0/0",
                     b1.rsp_valid, b1.rsp_id, b1.rsp_c, b1.rsp_c1, b1.rsp_c2);
        end
        b1.rsp_ready = 1;
        @(negedge clk);
        b1.rsp_ready = 0;
        checks++;
        if (b1.rsp_valid !== 1'b0 || b1.op_cnt !== 8'd1 || b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got v=%b op_cnt=%0d busy=%b expected 0/1/0",
                     b1.rsp_valid, b1.op_cnt, b1.busy);
        end
    endtask

    task automatic test_tie();
        apply_reset();  // last_grant back to 1 so req0 wins the tie
        b1.req0_valid = 1; b1.req0_a = 3'd5; b1.req0_b = 4'd15;
        b1.req1_valid = 1; b1.req1_a = 3'd7; b1.req1_b = 4'd7;
        b1.rsp_ready  = 1;
        #1;
        checks++;
        if (b1.req0_ready !== 1'b1 || b1.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie_first_grant: got r0=%b r1=%b expected 1/0", b1.req0_ready, b1.req1_ready);
        end
        @(negedge clk);  // ISSUE: nobody accepted
        checks++;
        if (b1.req0_ready !== 1'b0 || b1.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL tie_no_ready_issue: got r0=%b r1=%b expected 0/0", b1.req0_ready, b1.req1_ready);
        end
        @(negedge clk);  // RESP for req0
        checks++;
        if (b1.rsp_valid !== 1'b1 || b1.rsp_id !== 1'b0 || b1.rsp_c !== 5'd20 ||
            b1.rsp_c1 !== 1'b0 || b1.rsp_c2 !== 1'b0) begin
            errors++;
            $display("FAIL tie_rsp0: got v=%b id=%b c=%0d c1=%b c2=%b expected 1/0/20/0/0",
                     b1.rsp_valid, b1.rsp_id, b1.rsp_c, b1.rsp_c1, b1.rsp_c2);
        end
        @(negedge clk);  // back in IDLE, both still valid: req1's turn
        checks++;
        if (b1.req0_ready !== 1'b0 || b1.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL tie_second_grant: got r0=%b r1=%b expected 0/1", b1.req0_ready, b1.req1_ready);
        end
        @(negedge clk);
        b1.req0_valid = 0; b1.req1_valid = 0;
        @(negedge clk);  // RESP for req1
        checks++;
        if (b1.rsp_valid !== 1'b1 || b1.rsp_id !== 1'b1 || b1.rsp_c !== 5'd14 ||
            b1.rsp_c1 !== 1'b1 || b1.rsp_c2 !== 1'b0) begin
            errors++;
            $display("FAIL tie_rsp1: got v=%b id=%b c=%0d c1=%b c2=%b expected 1/1/14/1/0",
                     b1.rsp_valid, b1.rsp_id, b1.rsp_c, b1.rsp_c1, b1.rsp_c2);
        end
        @(negedge clk);
        b1.rsp_ready = 0;
        checks++;
        if (b1.op_cnt !== 8'd2 || b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_done: got op_cnt=%0d busy=%b expected 2/0", b1.op_cnt, b1.busy);
        end
    endtask

    task automatic test_backpressure();
        b1.req1_valid = 1; b1.req1_a = 3'd1; b1.req1_b = 4'd3; b1.rsp_ready = 0;
        @(negedge clk);
        b1.req1_valid = 0;
        b1.req0_valid = 1; b1.req0_a = 3'd4; b1.req0_b = 4'd4;  // waits, must not be accepted
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b1.rsp_valid !== 1'b1 || b1.rsp_c !== 5'd4 || b1.rsp_id !== 1'b1 ||
                b1.req0_ready !== 1'b0 || b1.req1_ready !== 1'b0 || b1.busy !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got v=%b c=%0d id=%b r0=%b r1=%b busy=%b expected 1/4/1/0/0/1",
                         i, b1.rsp_valid, b1.rsp_c, b1.rsp_id, b1.req0_ready, b1.req1_ready, b1.busy);
            end
            @(negedge clk);
        end
        b1.rsp_ready = 1; b1.req0_valid = 0;
        @(negedge clk);
        b1.rsp_ready = 0;
        checks++;
        if (b1.rsp_valid !== 1'b0 || b1.op_cnt !== 8'd3 || b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got v=%b op_cnt=%0d busy=%b expected 0/3/0",
                     b1.rsp_valid, b1.op_cnt, b1.busy);
        end
    endtask

    task automatic test_hold4();
        b4.req0_valid = 1; b4.req0_a = 3'd6; b4.req0_b = 4'd2; b4.rsp_ready = 0;
        #1;
        checks++;
        if (b4.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold4_ready: got %b expected 1", b4.req0_ready);
        end
        @(negedge clk);  // accept edge passed
        b4.req0_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (b4.rsp_valid !== (i == 4)) begin
                errors++;
                $display("FAIL hold4_latency edge %0d: got rsp_valid=%b expected %b",
                         i, b4.rsp_valid, (i == 4));
            end
        end
        checks++;
        if (b4.rsp_c !== 5'd8 || b4.rsp_c1 !== 1'b0 || b4.rsp_c2 !== 1'b1) begin
            errors++;
            $display("FAIL hold4_rsp: got c=%0d c1=%b c2=%b expected 8/0/1", b4.rsp_c, b4.rsp_c1, b4.rsp_c2);
        end
        b4.rsp_ready = 1;
        @(negedge clk);
        b4.rsp_ready = 0;
        checks++;
        if (b4.rsp_valid !== 1'b0 || b4.op_cnt !== 8'd1) begin
            errors++;
            $display("FAIL hold4_done: got v=%b op_cnt=%0d expected 0/1", b4.rsp_valid, b4.op_cnt);
        end
    endtask

    task automatic test_reset_mid_issue();
        b4.req0_valid = 1; b4.req0_a = 3'd5; b4.req0_b = 4'd1;
        @(negedge clk);  // accepted, ISSUE
        b4.req0_valid = 0;
        @(negedge clk);  // still ISSUE (3 settle cycles left)
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.rsp_valid, b4.rsp_id, b4.rsp_c, b4.rsp_c1, b4.rsp_c2,
             b4.req0_ready, b4.req1_ready, b4.busy} !== 12'd0 ||
            {b4.dp_a, b4.dp_b, b4.op_cnt} !== 15'd0) begin
            errors++;
            $display("FAIL midissue_reset_vals: got v=%b id=%b c=%0d busy=%b dp_a=%0d dp_b=%0d op_cnt=%0d expected all 0",
                     b4.rsp_valid, b4.rsp_id, b4.rsp_c, b4.busy, b4.dp_a, b4.dp_b, b4.op_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (b4.rsp_valid !== 1'b0 || b4.busy !== 1'b0) begin
                errors++;
                $display("FAIL midissue_no_rsp[%0d]: got v=%b busy=%b expected 0/0", i, b4.rsp_valid, b4.busy);
            end
        end
        b4.req0_valid = 1; b4.req1_valid = 1;
        #1;
        checks++;
        if (b4.req0_ready !== 1'b1 || b4.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midissue_tie_grant: got r0=%b r1=%b expected 1/0", b4.req0_ready, b4.req1_ready);
        end
        b4.req0_valid = 0; b4.req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        b1.rsp_ready = 1; b1.req0_a = 3'd1; b1.req0_b = 4'd1;
        for (int i = 1; i <= 256; i++) begin
            b1.req0_valid = 1;
            @(negedge clk);
            b1.req0_valid = 0;
            repeat (2) @(negedge clk);
            if (i == 255 || i == 256) begin
                checks++;
                if (b1.op_cnt !== 8'(i)) begin
                    errors++;
                    $display("FAIL wrap_op_cnt after %0d ops: got %0d expected %0d", i, b1.op_cnt, 8'(i));
                end
            end
        end
        b1.rsp_ready = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_hold4();
        test_reset_mid_issue();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
